// File: rtl/module_ctrl_mult_if.sv
// Handshake bundle between module_ctrl_mult and the keypad / converter / multiplier / display blocks.
// master = surrounding datapath (drives the event pulses), slave = the sequencer.
interface module_ctrl_mult_if;
    logic       listo_1;
    logic       listo_2;
    logic       conv_done;
    logic       mult_done;
    logic       clr;
    logic       mult_valid;
    logic [1:0] sel_disp;
    logic       busy;
    logic       err;
    logic [2:0] state_o;

    modport master (
        output listo_1, listo_2, conv_done, mult_done, clr,
        input  mult_valid, sel_disp, busy, err, state_o
    );

    modport slave (
        input  listo_1, listo_2, conv_done, mult_done, clr,
        output mult_valid, sel_disp, busy, err, state_o
    );
endinterface

// File: rtl/module_ctrl_mult.sv
// Sequencer for keypad -> BCD/bin -> Booth multiplier -> display; one start pulse per operand pair.
// Optional watchdog on the CONV+MUL wait, built in with macro WATCHDOG_EN.
module module_ctrl_mult #(
    parameter int unsigned HOLD_CYC    = 27_000_000,
    parameter int unsigned TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    module_ctrl_mult_if.slave  bus
);

    localparam int HOLD_W = $clog2(HOLD_CYC + 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_OP_A = 3'd1,
        ST_CONV = 3'd2,
        ST_MUL  = 3'd3,
        ST_SHOW = 3'd4,
        ST_ERR  = 3'd5
    } state_t;

    state_t            state_reg, state_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;
    logic              mult_valid_reg, mult_valid_next;
    logic [1:0]        sel_disp_reg, sel_disp_next;
    logic              busy_reg, busy_next;

`ifdef WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);
    localparam logic [WD_W-1:0] WD_MAX  = WD_W'(TIMEOUT_CYC);

    logic [WD_W-1:0] wd_reg, wd_next;
    logic            err_reg, err_next;
    logic            waiting;

    assign waiting = (state_reg == ST_CONV) || (state_reg == ST_MUL);
`endif

    always_comb begin
        state_next      = state_reg;
        hold_next       = hold_reg;
        mult_valid_next = 1'b0;
`ifdef WATCHDOG_EN
        wd_next  = wd_reg;
        err_next = err_reg;
        if (waiting && (wd_reg < WD_MAX))
            wd_next = wd_reg + WD_W'(1);
`endif
        if (bus.clr) begin
            state_next = ST_IDLE;
            hold_next  = '0;
`ifdef WATCHDOG_EN
            wd_next  = '0;
            err_next = 1'b0;
`endif
        end else
`ifdef WATCHDOG_EN
        // Timeout outranks any pulse arriving in the same cycle.
        if (waiting && (wd_reg >= WD_LAST)) begin
            state_next = ST_ERR;
            err_next   = 1'b1;
        end else
`endif
        begin
            case (state_reg)
                ST_IDLE: begin
                    if (bus.listo_1)
                        state_next = ST_OP_A;
                end
                ST_OP_A: begin
                    if (bus.listo_2) begin
                        state_next = ST_CONV;
`ifdef WATCHDOG_EN
                        wd_next = '0;
`endif
                    end
                end
                ST_CONV: begin
                    if (bus.conv_done) begin
                        state_next      = ST_MUL;
                        mult_valid_next = 1'b1;
                    end
                end
                ST_MUL: begin
                    if (bus.mult_done) begin
                        state_next = ST_SHOW;
                        hold_next  = '0;
                    end
                end
                ST_SHOW: begin
                    // A new operand A cuts the display hold short, even on the expiry cycle.
                    if (bus.listo_1) begin
                        state_next = ST_OP_A;
                        hold_next  = '0;
                    end else if (hold_reg >= HOLD_LAST) begin
                        state_next = ST_IDLE;
                        hold_next  = '0;
                    end else begin
                        hold_next = hold_reg + HOLD_W'(1);
                    end
                end
`ifdef WATCHDOG_EN
                ST_ERR: state_next = ST_ERR;
`endif
                default: state_next = ST_IDLE;
            endcase
        end

        // Display select and busy follow the state being entered so they stay aligned with state_o.
        case (state_next)
            ST_CONV, ST_MUL: sel_disp_next = 2'd1;
            ST_SHOW:         sel_disp_next = 2'd2;
            ST_ERR:          sel_disp_next = 2'd3;
            default:         sel_disp_next = 2'd0;
        endcase
        busy_next = (state_next == ST_CONV) || (state_next == ST_MUL);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg      <= ST_IDLE;
            hold_reg       <= '0;
            mult_valid_reg <= 1'b0;
            sel_disp_reg   <= 2'd0;
            busy_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            hold_reg       <= hold_next;
            mult_valid_reg <= mult_valid_next;
            sel_disp_reg   <= sel_disp_next;
            busy_reg       <= busy_next;
        end
    end

`ifdef WATCHDOG_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_reg  <= '0;
            err_reg <= 1'b0;
        end else begin
            wd_reg  <= wd_next;
            err_reg <= err_next;
        end
    end

    assign bus.err = err_reg;
`else
    // Without the watchdog the timeout length has no meaning.
    logic unused_timeout;
    assign unused_timeout = (TIMEOUT_CYC == 0);
    assign bus.err        = 1'b0;
`endif

    assign bus.mult_valid = mult_valid_reg;
    assign bus.sel_disp   = sel_disp_reg;
    assign bus.busy       = busy_reg;
    assign bus.state_o    = state_reg;

endmodule

// File: tb/tb_module_ctrl_mult.sv
// Directed bench for module_ctrl_mult: vector table for the main flow plus hand-written
// sequences for hold expiry vs listo_1, asynchronous reset and the watchdog.
module tb_module_ctrl_mult;

    localparam int HOLD = 8;
`ifdef WATCHDOG_EN
    // Long enough that the full flow in the table never trips the watchdog.
    localparam int TMO = 8;
`else
    localparam int TMO = 4;
`endif

    localparam logic [4:0] N  = 5'b00000;
    localparam logic [4:0] L1 = 5'b10000;
    localparam logic [4:0] L2 = 5'b01000;
    localparam logic [4:0] CD = 5'b00100;
    localparam logic [4:0] MD = 5'b00010;
    localparam logic [4:0] CL = 5'b00001;

    typedef struct {
        logic [4:0] stim;   // {listo_1, listo_2, conv_done, mult_done, clr}
        logic [2:0] st;
        logic [1:0] sel;
        logic       busy;
        logic       mv;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    module_ctrl_mult_if bus ();

    module_ctrl_mult #(
        .HOLD_CYC    (HOLD),
        .TIMEOUT_CYC (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    vec_t vecs[36];

    function automatic vec_t mk(logic [4:0] s, int st, int sel, int busy, int mv);
        vec_t r;
        r.stim = s;
        r.st   = 3'(st);
        r.sel  = 2'(sel);
        r.busy = 1'(busy);
        r.mv   = 1'(mv);
        return r;
    endfunction

    task automatic drive(input logic [4:0] s);
        bus.listo_1   = s[4];
        bus.listo_2   = s[3];
        bus.conv_done = s[2];
        bus.mult_done = s[1];
        bus.clr       = s[0];
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int st, input int sel, input int busy,
                           input int mv, input int err);
        $display("[TB] %s: state=%0d sel=%0d busy=%0d mv=%0d err=%0d (exp %0d %0d %0d %0d %0d)",
                 tag, bus.state_o, bus.sel_disp, bus.busy, bus.mult_valid, bus.err,
                 st, sel, busy, mv, err);
        chk({tag, ".state"}, int'(bus.state_o), st);
        chk({tag, ".sel"},   int'(bus.sel_disp), sel);
        chk({tag, ".busy"},  int'(bus.busy), busy);
        chk({tag, ".mv"},    int'(bus.mult_valid), mv);
        chk({tag, ".err"},   int'(bus.err), err);
    endtask

    initial begin
        // Full flow (HOLD=8): each entry's expectation is the state after that cycle's edge.
        vecs[0]  = mk(N,  0, 0, 0, 0);
        vecs[1]  = mk(N,  0, 0, 0, 0);
        vecs[2]  = mk(L1, 1, 0, 0, 0);
        vecs[3]  = mk(N,  1, 0, 0, 0);
        vecs[4]  = mk(N,  1, 0, 0, 0);
        vecs[5]  = mk(L2, 2, 1, 1, 0);
        vecs[6]  = mk(N,  2, 1, 1, 0);
        vecs[7]  = mk(N,  2, 1, 1, 0);
        vecs[8]  = mk(CD, 3, 1, 1, 1);
        vecs[9]  = mk(N,  3, 1, 1, 0);
        vecs[10] = mk(N,  3, 1, 1, 0);
        vecs[11] = mk(N,  3, 1, 1, 0);
        vecs[12] = mk(MD, 4, 2, 0, 0);
        for (int i = 13; i <= 19; i++) vecs[i] = mk(N, 4, 2, 0, 0);
        vecs[20] = mk(N,  0, 0, 0, 0);
        vecs[21] = mk(MD, 0, 0, 0, 0);
        // Ignored pulses in IDLE, simultaneous A/B, re-entry of A, extra conv_done in MUL, clr in MUL.
        vecs[22] = mk(L2,      0, 0, 0, 0);
        vecs[23] = mk(CD,      0, 0, 0, 0);
        vecs[24] = mk(MD,      0, 0, 0, 0);
        vecs[25] = mk(L1 | L2, 1, 0, 0, 0);
        vecs[26] = mk(N,       1, 0, 0, 0);
        vecs[27] = mk(MD,      1, 0, 0, 0);
        vecs[28] = mk(L1,      1, 0, 0, 0);
        vecs[29] = mk(L1 | L2, 2, 1, 1, 0);
        vecs[30] = mk(N,       2, 1, 1, 0);
        vecs[31] = mk(CD,      3, 1, 1, 1);
        vecs[32] = mk(CD,      3, 1, 1, 0);
        vecs[33] = mk(CL,      0, 0, 0, 0);
        vecs[34] = mk(MD,      0, 0, 0, 0);
        vecs[35] = mk(CD,      0, 0, 0, 0);

        drive(N);
        rst = 1'b1;
        tick;
        tick;
        chk_all("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;

        for (int i = 0; i < 36; i++) begin
            drive(vecs[i].stim);
            tick;
            chk_all($sformatf("vec%0d", i), int'(vecs[i].st), int'(vecs[i].sel),
                    int'(vecs[i].busy), int'(vecs[i].mv), 0);
        end

        // listo_1 on the exact hold-expiry cycle wins over the return to IDLE.
        drive(L1); tick;
        drive(L2); tick;
        drive(CD); tick;
        drive(MD); tick;
        chk_all("t4_show", 4, 2, 0, 0, 0);
        drive(N);
        repeat (HOLD - 1) tick;
        chk_all("t4_last", 4, 2, 0, 0, 0);
        drive(L1); tick;
        chk_all("t4_opa", 1, 0, 0, 0, 0);

        // Reset pulsed between edges while a conv_done is pending.
        drive(L2); tick;
        chk_all("t5_conv", 2, 1, 1, 0, 0);
        drive(CD);
        #2 rst = 1'b1;
        #1 chk_all("t5_async", 0, 0, 0, 0, 0);
        #1 rst = 1'b0;
        tick;
        chk_all("t5_after", 0, 0, 0, 0, 0);
        drive(N);

        // CONV with no conv_done ever arriving.
        drive(L1); tick;
        drive(L2); tick;
        drive(N);
`ifdef WATCHDOG_EN
        repeat (TMO - 1) tick;
        chk_all("t6_wait", 2, 1, 1, 0, 0);
        tick;
        chk_all("t6_err", 5, 3, 0, 0, 1);
        tick;
        chk_all("t6_hold", 5, 3, 0, 0, 1);
        drive(CL); tick;
        chk_all("t6_clr", 0, 0, 0, 0, 0);
        drive(N);
`else
        repeat (TMO + 6) tick;
        chk_all("t6_nowd", 2, 1, 1, 0, 0);
        drive(CL); tick;
        chk_all("t6_clr", 0, 0, 0, 0, 0);
        drive(N);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
